matinv_seq_ctrl: RTL and testbench

- Sequential controller wrapping one combinational `matinv<N>` instance (N = MATRIX_SIZE).
- Loads an N×N fixed-point matrix element by element over a valid/ready stream.
- Holds the operands stable for a programmable multicycle settle window, then captures the inverse and the singular flag.
- Streams the result out over a second valid/ready stream.
- Sits between the navigation state-update logic and the inverter, so the long combinational path never lands on a single-cycle timing path.

---
 rtl/matinv_pkg.sv | 39 +++
 rtl/matinv.sv | 114 +++++++++++
 rtl/matinv_seq_ctrl.sv | 160 ++++++++++++++++
 tb/tb_matinv_seq_ctrl.sv | 273 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/matinv_pkg.sv
// Shared types and helpers for the sequential matrix-inverse controller
// and the combinational matinv2/3/4 inverters.
package matinv_pkg;

    typedef enum logic [1:0] {LOAD, SETTLE, DRAIN} state_t;

    localparam int DEF_DATA_WIDTH = 32;
    localparam int DEF_BIN_POS    = 16;

    // Wide enough for a 4x4 determinant of 32-bit elements plus the
    // 2*BIN_POS pre-scale applied before the division.
    localparam int WIDE_W = 256;
    typedef logic signed [WIDE_W-1:0] wide_t;

    function automatic int elem_count(input int n);
        return n * n;
    endfunction

    function automatic wide_t det2(input wide_t a, input wide_t b,
                                   input wide_t c, input wide_t d);
        return a * d - b * c;
    endfunction

    function automatic wide_t det3(input wide_t a, input wide_t b, input wide_t c,
                                   input wide_t d, input wide_t e, input wide_t f,
                                   input wide_t g, input wide_t h, input wide_t i);
        return a * det2(e, f, h, i) - b * det2(d, f, g, i) + c * det2(d, e, g, h);
    endfunction

    // Fixed-point inverse element: cofactor * 2^(2*bin_pos) / det.
    // A zero determinant yields zero rather than an undefined quotient.
    function automatic wide_t fx_div(input wide_t cof, input wide_t det, input int bin_pos);
        if (det == '0) begin
            return '0;
        end
        return (cof <<< (2 * bin_pos)) / det;
    endfunction

endpackage

// File: rtl/matinv.sv
// Combinational fixed-point inverters (adjugate / determinant) for
// 2x2, 3x3 and 4x4 matrices, row-major packed elements.
module matinv2 import matinv_pkg::*; #(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int BIN_POS    = DEF_BIN_POS
) (
    input  logic [4*DATA_WIDTH-1:0] i_matrix,
    output logic [4*DATA_WIDTH-1:0] o_inverse,
    output logic                    o_singular
);
    wide_t w_m   [4];
    wide_t w_cof [4];
    wide_t w_det;

    genvar gi;
    for (gi = 0; gi < 4; gi++) begin : g_elem
        assign w_m[gi] = wide_t'($signed(i_matrix[gi*DATA_WIDTH +: DATA_WIDTH]));
    end

    assign w_cof[0] =  w_m[3];
    assign w_cof[1] = -w_m[2];
    assign w_cof[2] = -w_m[1];
    assign w_cof[3] =  w_m[0];
    assign w_det    = det2(w_m[0], w_m[1], w_m[2], w_m[3]);

    // inverse(i,j) is the transposed cofactor C(j,i) over the determinant
    for (gi = 0; gi < 4; gi++) begin : g_out
        assign o_inverse[gi*DATA_WIDTH +: DATA_WIDTH] =
            DATA_WIDTH'(fx_div(w_cof[(gi%2)*2 + gi/2], w_det, BIN_POS));
    end
    assign o_singular = (w_det == '0);
endmodule

module matinv3 import matinv_pkg::*; #(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int BIN_POS    = DEF_BIN_POS
) (
    input  logic [9*DATA_WIDTH-1:0] i_matrix,
    output logic [9*DATA_WIDTH-1:0] o_inverse,
    output logic                    o_singular
);
    wide_t w_m   [9];
    wide_t w_cof [9];
    wide_t w_det;

    genvar gi, gj;
    for (gi = 0; gi < 9; gi++) begin : g_elem
        assign w_m[gi] = wide_t'($signed(i_matrix[gi*DATA_WIDTH +: DATA_WIDTH]));
    end

    // Minor rows/cols are the two indices other than (gi, gj), in order
    for (gi = 0; gi < 3; gi++) begin : g_r
        for (gj = 0; gj < 3; gj++) begin : g_c
            localparam int RA = (gi == 0) ? 1 : 0;
            localparam int RB = (gi == 2) ? 1 : 2;
            localparam int CA = (gj == 0) ? 1 : 0;
            localparam int CB = (gj == 2) ? 1 : 2;
            wide_t w_minor;
            assign w_minor = det2(w_m[RA*3+CA], w_m[RA*3+CB], w_m[RB*3+CA], w_m[RB*3+CB]);
            assign w_cof[gi*3+gj] = (((gi + gj) % 2) == 1) ? -w_minor : w_minor;
        end
    end

    assign w_det = w_m[0]*w_cof[0] + w_m[1]*w_cof[1] + w_m[2]*w_cof[2];

    for (gi = 0; gi < 9; gi++) begin : g_out
        assign o_inverse[gi*DATA_WIDTH +: DATA_WIDTH] =
            DATA_WIDTH'(fx_div(w_cof[(gi%3)*3 + gi/3], w_det, BIN_POS));
    end
    assign o_singular = (w_det == '0);
endmodule

module matinv4 import matinv_pkg::*; #(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int BIN_POS    = DEF_BIN_POS
) (
    input  logic [16*DATA_WIDTH-1:0] i_matrix,
    output logic [16*DATA_WIDTH-1:0] o_inverse,
    output logic                     o_singular
);
    wide_t w_m   [16];
    wide_t w_cof [16];
    wide_t w_det;

    genvar gi, gj;
    for (gi = 0; gi < 16; gi++) begin : g_elem
        assign w_m[gi] = wide_t'($signed(i_matrix[gi*DATA_WIDTH +: DATA_WIDTH]));
    end

    // Minor rows/cols are the three indices other than (gi, gj), in order
    for (gi = 0; gi < 4; gi++) begin : g_r
        for (gj = 0; gj < 4; gj++) begin : g_c
            localparam int RA = (gi == 0) ? 1 : 0;
            localparam int RB = (gi <= 1) ? 2 : 1;
            localparam int RC = (gi == 3) ? 2 : 3;
            localparam int CA = (gj == 0) ? 1 : 0;
            localparam int CB = (gj <= 1) ? 2 : 1;
            localparam int CC = (gj == 3) ? 2 : 3;
            wide_t w_minor;
            assign w_minor = det3(w_m[RA*4+CA], w_m[RA*4+CB], w_m[RA*4+CC],
                                  w_m[RB*4+CA], w_m[RB*4+CB], w_m[RB*4+CC],
                                  w_m[RC*4+CA], w_m[RC*4+CB], w_m[RC*4+CC]);
            assign w_cof[gi*4+gj] = (((gi + gj) % 2) == 1) ? -w_minor : w_minor;
        end
    end

    assign w_det = w_m[0]*w_cof[0] + w_m[1]*w_cof[1] + w_m[2]*w_cof[2] + w_m[3]*w_cof[3];

    for (gi = 0; gi < 16; gi++) begin : g_out
        assign o_inverse[gi*DATA_WIDTH +: DATA_WIDTH] =
            DATA_WIDTH'(fx_div(w_cof[(gi%4)*4 + gi/4], w_det, BIN_POS));
    end
    assign o_singular = (w_det == '0);
endmodule

// File: rtl/matinv_seq_ctrl.sv
// Sequential wrapper around a combinational matinv<N>: streams a matrix in,
// holds it for SETTLE_CYCLES clocks, captures the inverse, streams it out.
// Optional statistics counters: define MATINV_SEQ_CTRL_STATS_EN.
module matinv_seq_ctrl import matinv_pkg::*; #(
    parameter int DATA_WIDTH    = DEF_DATA_WIDTH,
    parameter int BIN_POS       = DEF_BIN_POS,
    parameter int MATRIX_SIZE   = 3,
    parameter int SETTLE_CYCLES = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  abort,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [DATA_WIDTH-1:0] in_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic                  out_last,
    output logic                  out_singular,
    output logic                  busy
`ifdef MATINV_SEQ_CTRL_STATS_EN
    ,
    output logic [15:0]           stat_done,
    output logic [15:0]           stat_singular
`endif
);
    localparam int NN    = elem_count(MATRIX_SIZE);
    localparam int IDX_W = $clog2(NN);
    localparam int MAT_W = NN * DATA_WIDTH;
    localparam int CNT_W = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NN - 1);
    localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(SETTLE_CYCLES - 1);

    state_t                  r_state;
    logic [IDX_W-1:0]        r_idx;
    logic [CNT_W-1:0]        r_cnt;
    logic [MAT_W-1:0]        r_matrix;
    logic [MAT_W-1:0]        r_result;
    logic                    r_out_valid;
    logic [DATA_WIDTH-1:0]   r_out_data;
    logic                    r_out_last;
    logic                    r_out_singular;
    logic [MAT_W-1:0]        w_inverse;
    logic                    w_singular;
    logic [IDX_W-1:0]        w_next_idx;

    assign w_next_idx   = r_idx + 1'b1;
    assign in_ready     = (r_state == LOAD);
    assign busy         = (r_state != LOAD);
    assign out_valid    = r_out_valid;
    assign out_data     = r_out_data;
    assign out_last     = r_out_last;
    assign out_singular = r_out_singular;

    // The inverter sees only the matrix register; its outputs feed capture only
    generate
        case (MATRIX_SIZE)
            2: begin : g_inv2
                matinv2 #(.DATA_WIDTH(DATA_WIDTH), .BIN_POS(BIN_POS)) u_inv (
                    .i_matrix(r_matrix), .o_inverse(w_inverse), .o_singular(w_singular));
            end
            3: begin : g_inv3
                matinv3 #(.DATA_WIDTH(DATA_WIDTH), .BIN_POS(BIN_POS)) u_inv (
                    .i_matrix(r_matrix), .o_inverse(w_inverse), .o_singular(w_singular));
            end
            4: begin : g_inv4
                matinv4 #(.DATA_WIDTH(DATA_WIDTH), .BIN_POS(BIN_POS)) u_inv (
                    .i_matrix(r_matrix), .o_inverse(w_inverse), .o_singular(w_singular));
            end
            default: begin : g_inv_none
                assign w_inverse  = '0;
                assign w_singular = 1'b1;
            end
        endcase
    endgenerate

    // Load / settle / drain sequencer with registered stream outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state        <= LOAD;
            r_idx          <= '0;
            r_cnt          <= '0;
            r_matrix       <= '0;
            r_result       <= '0;
            r_out_valid    <= 1'b0;
            r_out_data     <= '0;
            r_out_last     <= 1'b0;
            r_out_singular <= 1'b0;
        end else if (abort) begin
            r_state        <= LOAD;
            r_idx          <= '0;
            r_out_valid    <= 1'b0;
            r_out_last     <= 1'b0;
            r_out_singular <= 1'b0;
        end else begin
            case (r_state)
                LOAD: begin
                    if (in_valid) begin
                        r_matrix[r_idx*DATA_WIDTH +: DATA_WIDTH] <= in_data;
                        if (r_idx == LAST_IDX) begin
                            r_state <= SETTLE;
                            r_idx   <= '0;
                            r_cnt   <= CNT_INIT;
                        end else begin
                            r_idx <= w_next_idx;
                        end
                    end
                end
                SETTLE: begin
                    if (r_cnt == '0) begin
                        r_result       <= w_inverse;
                        r_state        <= DRAIN;
                        r_out_valid    <= 1'b1;
                        r_out_singular <= w_singular;
                        r_out_last     <= w_singular;
                        r_out_data     <= w_singular ? '0 : w_inverse[DATA_WIDTH-1:0];
                    end else begin
                        r_cnt <= r_cnt - 1'b1;
                    end
                end
                DRAIN: begin
                    if (out_ready) begin
                        if (r_out_last) begin
                            r_state        <= LOAD;
                            r_idx          <= '0;
                            r_out_valid    <= 1'b0;
                            r_out_data     <= '0;
                            r_out_last     <= 1'b0;
                            r_out_singular <= 1'b0;
                        end else begin
                            r_idx      <= w_next_idx;
                            r_out_data <= r_result[w_next_idx*DATA_WIDTH +: DATA_WIDTH];
                            r_out_last <= (w_next_idx == LAST_IDX);
                        end
                    end
                end
                default: r_state <= LOAD;
            endcase
        end
    end

`ifdef MATINV_SEQ_CTRL_STATS_EN
    // Saturating counts of completed and singular results; abort leaves them alone
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stat_done     <= '0;
            stat_singular <= '0;
        end else if (!abort && r_out_valid && out_ready && r_out_last) begin
            if (stat_done != 16'hFFFF) begin
                stat_done <= stat_done + 16'd1;
            end
            if (r_out_singular && (stat_singular != 16'hFFFF)) begin
                stat_singular <= stat_singular + 16'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_matinv_seq_ctrl.sv
// Directed plus randomized bench for matinv_seq_ctrl with N=2.
module tb_matinv_seq_ctrl;
    localparam int DW = 32;
    localparam int BP = 16;
    localparam int N  = 2;
    localparam int S  = 4;
    localparam logic [31:0] ONE = 32'h0001_0000;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        abort = 1'b0;
    logic        in_valid = 1'b0;
    logic        out_ready = 1'b0;
    logic [31:0] in_data = '0;
    logic        in_ready, out_valid, out_last, out_singular, busy;
    logic [31:0] out_data;
`ifdef MATINV_SEQ_CTRL_STATS_EN
    logic [15:0] stat_done, stat_singular;
    int          m_done = 0;
    int          m_sing = 0;
`endif

    int          n_cmp = 0;
    int          n_err = 0;
    logic [31:0] mat_q [4];
    logic [31:0] exp_q [4];
    int          exp_beats;
    logic        exp_sing;
    int          lat;

    always #5 clk = ~clk;

    matinv_seq_ctrl #(.DATA_WIDTH(DW), .BIN_POS(BP), .MATRIX_SIZE(N), .SETTLE_CYCLES(S)) dut (
        .clk(clk), .rst_n(rst_n), .abort(abort),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .out_last(out_last), .out_singular(out_singular), .busy(busy)
`ifdef MATINV_SEQ_CTRL_STATS_EN
        , .stat_done(stat_done), .stat_singular(stat_singular)
`endif
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Signed power of two in raw fixed-point units
    function automatic logic [31:0] p2(input int s, input int k);
        int v;
        v = 1 << k;
        return (s < 0) ? -v : v;
    endfunction

    task automatic load4();
        int w;
        for (int i = 0; i < 4; i++) begin
            w = 0;
            in_valid = 1'b1;
            in_data  = mat_q[i];
            while (!in_ready && w < 50) begin
                tick();
                w++;
            end
            chk("load_ready", {31'd0, in_ready}, 32'd1);
            tick();
        end
        in_valid = 1'b0;
        $display("load %h %h %h %h", mat_q[0], mat_q[1], mat_q[2], mat_q[3]);
    endtask

    task automatic wait_valid(output int cyc);
        cyc = 0;
        while (!out_valid && cyc < 50) begin
            tick();
            cyc++;
        end
    endtask

    // Expectation for a matrix built from signed powers of two (type 0 diag,
    // 1 anti-diagonal) or equal rows (type 2, singular).
    task automatic gen_case(input int typ);
        int s1, s2, k1, k2;
        logic [31:0] r0, r1;
        s1 = ($urandom_range(0, 1) == 1) ? 1 : -1;
        s2 = ($urandom_range(0, 1) == 1) ? 1 : -1;
        k1 = $urandom_range(14, 18);
        k2 = $urandom_range(14, 18);
        exp_q = '{32'd0, 32'd0, 32'd0, 32'd0};
        if (typ == 0) begin
            mat_q = '{p2(s1, k1), 32'd0, 32'd0, p2(s2, k2)};
            exp_q = '{p2(s1, 32 - k1), 32'd0, 32'd0, p2(s2, 32 - k2)};
            exp_beats = 4; exp_sing = 1'b0;
        end else if (typ == 1) begin
            mat_q = '{32'd0, p2(s1, k1), p2(s2, k2), 32'd0};
            exp_q = '{32'd0, p2(s2, 32 - k2), p2(s1, 32 - k1), 32'd0};
            exp_beats = 4; exp_sing = 1'b0;
        end else begin
            r0 = $urandom; r1 = $urandom;
            mat_q = '{r0, r1, r0, r1};
            exp_beats = 1; exp_sing = 1'b1;
        end
    endtask

    // mode 0: always ready, 1: ready pattern 1,0,0 repeating, 2: random
    task automatic drain(input int mode);
        int beat, budget, c;
        logic stalled, rdy, h_last, h_sing;
        logic [31:0] h_data;
        beat = 0; budget = 100; c = 0; stalled = 1'b0;
        h_last = 1'b0; h_sing = 1'b0; h_data = '0;
        while (beat < exp_beats && budget > 0) begin
            rdy = (mode == 0) ? 1'b1 : (mode == 1) ? ((c % 3) == 0) : 1'($urandom_range(0, 1));
            out_ready = rdy;
            chk("drain_in_ready", {31'd0, in_ready}, 32'd0);
            if (stalled) begin
                chk("hold_valid", {31'd0, out_valid}, 32'd1);
                chk("hold_data", out_data, h_data);
                chk("hold_last", {31'd0, out_last}, {31'd0, h_last});
                chk("hold_sing", {31'd0, out_singular}, {31'd0, h_sing});
            end
            if (out_valid && rdy) begin
                chk("beat_data", out_data, exp_q[beat]);
                chk("beat_last", {31'd0, out_last}, {31'd0, (beat == exp_beats - 1)});
                chk("beat_sing", {31'd0, out_singular}, {31'd0, exp_sing});
                $display("beat %0d data=%h last=%b sing=%b", beat, out_data, out_last, out_singular);
                beat++;
                stalled = 1'b0;
            end else if (out_valid) begin
                stalled = 1'b1;
                h_data = out_data; h_last = out_last; h_sing = out_singular;
            end
            tick();
            c++;
            budget--;
        end
        out_ready = 1'b0;
        chk("drain_beats", beat, exp_beats);
        chk("post_in_ready", {31'd0, in_ready}, 32'd1);
        chk("post_out_valid", {31'd0, out_valid}, 32'd0);
`ifdef MATINV_SEQ_CTRL_STATS_EN
        m_done++;
        if (exp_sing) m_sing++;
        chk("stat_done", {16'd0, stat_done}, m_done);
        chk("stat_singular", {16'd0, stat_singular}, m_sing);
`endif
    endtask

    task automatic run_case(input int mode);
        load4();
        chk("settle_busy", {31'd0, busy}, 32'd1);
        wait_valid(lat);
        chk("latency", lat, S);
        drain(mode);
    endtask

    initial begin
        // Reset state
        repeat (2) tick();
        chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("rst_out_data", out_data, 32'd0);
        chk("rst_out_last", {31'd0, out_last}, 32'd0);
        chk("rst_out_sing", {31'd0, out_singular}, 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        rst_n = 1'b1;
        tick();
        chk("rst_in_ready", {31'd0, in_ready}, 32'd1);

        // Identity
        mat_q = '{ONE, 32'd0, 32'd0, ONE};
        exp_q = '{ONE, 32'd0, 32'd0, ONE};
        exp_beats = 4; exp_sing = 1'b0;
        run_case(0);

        // Diagonal [[2,0],[0,4]]
        mat_q = '{32'h0002_0000, 32'd0, 32'd0, 32'h0004_0000};
        exp_q = '{32'h0000_8000, 32'd0, 32'd0, 32'h0000_4000};
        run_case(0);

        // All-zero: single singular beat
        mat_q = '{32'd0, 32'd0, 32'd0, 32'd0};
        exp_q = '{32'd0, 32'd0, 32'd0, 32'd0};
        exp_beats = 1; exp_sing = 1'b1;
        run_case(0);

        // Backpressure with toggling ready
        mat_q = '{32'h0002_0000, 32'd0, 32'd0, 32'h0004_0000};
        exp_q = '{32'h0000_8000, 32'd0, 32'd0, 32'h0000_4000};
        exp_beats = 4; exp_sing = 1'b0;
        run_case(1);

        // Abort after two elements, with an element offered in the abort cycle
        for (int i = 0; i < 2; i++) begin
            in_valid = 1'b1;
            in_data  = 32'hDEAD_0000 + i;
            tick();
        end
        abort = 1'b1;
        in_data = 32'hBEEF_0000;
        tick();
        abort = 1'b0;
        in_valid = 1'b0;
        chk("abort_in_ready", {31'd0, in_ready}, 32'd1);
        chk("abort_busy", {31'd0, busy}, 32'd0);
        $display("abort during load");
        mat_q = '{ONE, 32'd0, 32'd0, ONE};
        exp_q = '{ONE, 32'd0, 32'd0, ONE};
        run_case(2);

        // Abort during drain
        mat_q = '{32'h0002_0000, 32'd0, 32'd0, 32'h0004_0000};
        load4();
        wait_valid(lat);
        chk("abort_drain_valid_pre", {31'd0, out_valid}, 32'd1);
        tick();
        abort = 1'b1;
        out_ready = 1'b1;
        tick();
        abort = 1'b0;
        out_ready = 1'b0;
        chk("abort_drain_valid", {31'd0, out_valid}, 32'd0);
        chk("abort_drain_ready", {31'd0, in_ready}, 32'd1);
        chk("abort_drain_busy", {31'd0, busy}, 32'd0);
        $display("abort during drain");

        // Randomized matrices and backpressure
        for (int t = 0; t < 8; t++) begin
            gen_case($urandom_range(0, 2));
            run_case($urandom_range(0, 2));
        end

        // Reset in the middle of a drain
        mat_q = '{ONE, 32'd0, 32'd0, ONE};
        load4();
        wait_valid(lat);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        chk("mid_rst_valid", {31'd0, out_valid}, 32'd0);
        chk("mid_rst_data", out_data, 32'd0);
        chk("mid_rst_last", {31'd0, out_last}, 32'd0);
        chk("mid_rst_sing", {31'd0, out_singular}, 32'd0);
        chk("mid_rst_busy", {31'd0, busy}, 32'd0);
        tick();
        rst_n = 1'b1;
        tick();
        chk("mid_rst_in_ready", {31'd0, in_ready}, 32'd1);
`ifdef MATINV_SEQ_CTRL_STATS_EN
        chk("mid_rst_stat_done", {16'd0, stat_done}, 32'd0);
        chk("mid_rst_stat_sing", {16'd0, stat_singular}, 32'd0);
        m_done = 0;
        m_sing = 0;
`endif
        $display("reset during drain");
        exp_q = '{ONE, 32'd0, 32'd0, ONE};
        exp_beats = 4; exp_sing = 1'b0;
        run_case(1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
